axil_bram_ctrl: RTL and testbench

AXI4-Lite slave that drives one port of the on-chip dual-port block RAM.
- Sits directly upstream of the RAM and serves the core's data/instruction interconnect.
- Converts AW/W/B and AR/R channel handshakes into RAM enable, write-enable, byte-strobe, word-address and data signals.
- Absorbs the RAM's 1-cycle synchronous read latency.
- Arbitrates reads against writes onto the single RAM port.

---
 rtl/axil_bram_pkg.sv | 31 +++
 rtl/axil_bram_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_axil_bram_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_bram_pkg.sv
// axil_bram_pkg: shared types and helpers for the AXI4-Lite block-RAM controller.
// Holds the controller FSM state encoding, the AXI response codes and the
// byte-to-word address helpers used by axil_bram_ctrl.
package axil_bram_pkg;

    // Controller FSM states; one transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        RD_WAIT = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    // AXI response codes used on BRESP / RRESP.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address to RAM word address: the two byte-lane bits are dropped,
    // the caller truncates the result to its RAM address width.
    function automatic logic [63:0] word_addr(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

    // True when the byte address has any bit set above the RAM's word range.
    function automatic logic addr_out_of_range(input logic [63:0] byte_addr,
                                               input int unsigned ram_addr_width);
        return (byte_addr >> (ram_addr_width + 2)) != 64'd0;
    endfunction

endpackage

// File: rtl/axil_bram_ctrl.sv
// axil_bram_ctrl: AXI4-Lite slave driving one port of a synchronous block RAM.
//
// One transaction is in flight at a time. Reads and writes compete for the
// single RAM port through a round-robin pointer that starts at read priority.
// All outputs are registered. A granted transaction runs as:
//   write: grant cycle (AWREADY/WREADY pulse), RAM write cycle, then BVALID.
//   read : grant cycle (ARREADY pulse + RAM enable), RAM latency cycle, then RVALID.
// Either way the response is valid two cycles after the address handshake cycle.
//
// Optional feature: define AXIL_BRAM_RANGE_CHECK_EN to reject accesses whose
// byte address has bits set above ADDR_WIDTH+1 with SLVERR (no RAM access,
// read data zero). Without it, upper address bits are ignored and accesses
// alias into the RAM.
module axil_bram_ctrl
    import axil_bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    // AXI4-Lite write address / data / response
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,

    // AXI4-Lite read address / data
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    // Block RAM port
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [DATA_WIDTH/8-1:0]   ram_wstrb,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    input  logic [DATA_WIDTH-1:0]     ram_dout
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                state;
    logic                  rd_priority;   // 1: read wins a tie, 0: write wins
    logic [STRB_WIDTH-1:0] wr_strb;       // strobes latched at the write grant
    logic                  wr_err;        // latched: write target out of range
    logic                  rd_err;        // latched: read target out of range

    logic                  wr_eligible;
    logic                  rd_eligible;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  wr_addr_bad;
    logic                  rd_addr_bad;

    // Address range qualification of the incoming requests.
`ifdef AXIL_BRAM_RANGE_CHECK_EN
    assign wr_addr_bad = addr_out_of_range(64'(s_awaddr), ADDR_WIDTH);
    assign rd_addr_bad = addr_out_of_range(64'(s_araddr), ADDR_WIDTH);
`else
    assign wr_addr_bad = 1'b0;
    assign rd_addr_bad = 1'b0;
`endif

    // Arbitration between an eligible read and an eligible write in IDLE.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        wr_eligible = 1'b0;
        rd_eligible = 1'b0;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        if (state == IDLE) begin
            // A write needs both address and data; neither half is taken alone.
            wr_eligible = s_awvalid && s_wvalid;
            rd_eligible = s_arvalid;
            grant_rd    = rd_eligible && (!wr_eligible || rd_priority);
            grant_wr    = wr_eligible && !grant_rd;
        end
    end

    // Controller FSM with all AXI and RAM outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            state       <= IDLE;
            rd_priority <= 1'b1;
            wr_strb     <= '0;
            wr_err      <= 1'b0;
            rd_err      <= 1'b0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            s_bvalid    <= 1'b0;
            s_arready   <= 1'b0;
            s_rdata     <= '0;
            s_rresp     <= RESP_OKAY;
            s_rvalid    <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_wstrb   <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        // Read grant: the RAM is enabled in the ARREADY cycle itself.
                        s_arready   <= 1'b1;
                        ram_en      <= !rd_addr_bad;
                        ram_we      <= 1'b0;
                        ram_wstrb   <= '0;
                        ram_addr    <= ADDR_WIDTH'(word_addr(64'(s_araddr)));
                        rd_err      <= rd_addr_bad;
                        rd_priority <= 1'b0;
                        state       <= RD_WAIT;
                    end else if (grant_wr) begin
                        // Write grant: capture the whole request, write it next cycle.
                        s_awready   <= 1'b1;
                        s_wready    <= 1'b1;
                        ram_addr    <= ADDR_WIDTH'(word_addr(64'(s_awaddr)));
                        ram_din     <= s_wdata;
                        wr_strb     <= s_wstrb;
                        wr_err      <= wr_addr_bad;
                        rd_priority <= 1'b1;
                        state       <= WRITE;
                    end
                end

                WRITE: begin
                    if (s_awready) begin
                        // Handshake cycle done: issue the single RAM write cycle.
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        ram_en    <= !wr_err;
                        ram_we    <= !wr_err;
                        ram_wstrb <= wr_err ? '0 : wr_strb;
                    end else begin
                        // RAM write cycle done: raise the response.
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_wstrb <= '0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        state     <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        s_bresp  <= RESP_OKAY;
                        state    <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (s_arready) begin
                        // RAM sampled the address at this edge; data appears next cycle.
                        s_arready <= 1'b0;
                        ram_en    <= 1'b0;
                    end else begin
                        // RAM output is valid now: capture it into the response register.
                        s_rdata  <= rd_err ? '0 : ram_dout;
                        s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        s_rvalid <= 1'b1;
                        state    <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// tb_axil_bram_ctrl: self-checking bench for axil_bram_ctrl.
// Provides a behavioural block RAM on the DUT's RAM port, a table of directed
// transactions, hand-written sequences for arbitration, split AW/W arrival and
// reset abandonment, and a randomized run against a word-array memory model.
// Honours AXIL_BRAM_RANGE_CHECK_EN when the design is built with it.
module tb_axil_bram_ctrl;
    import axil_bram_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int TMO   = 50;

`ifdef AXIL_BRAM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_wstrb;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    axil_bram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous block RAM on the DUT's RAM port.
    logic        ram_clear;
    logic [31:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'd0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    // RAM port activity monitor, sampled mid-cycle.
    int          mon_wr_cnt = 0;
    int          mon_rd_cnt = 0;
    int          mon_en_cnt = 0;
    logic [AW-1:0] mon_waddr;
    logic [31:0] mon_wdata;
    logic [3:0]  mon_wstrb;
    always @(negedge clk) begin
        if (ram_en) mon_en_cnt++;
        if (ram_en && ram_we) begin
            mon_wr_cnt++;
            mon_waddr = ram_addr;
            mon_wdata = ram_din;
            mon_wstrb = ram_wstrb;
        end
        if (ram_en && !ram_we) mon_rd_cnt++;
    end

    // Reference model: a plain word array updated per completed write.
    logic [31:0] shadow [0:DEPTH-1];

    function automatic bit model_oob(input logic [31:0] a);
        return RANGE_CHECK && ((a >> (AW + 2)) != 32'd0);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!model_oob(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) shadow[model_idx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_oob(a) ? 32'd0 : shadow[model_idx(a)];
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One AXI write; checks grant, RAM write cycle, response latency and code.
    task automatic axi_write(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n;
        int wc0;
        bit oob;
        oob = model_oob(a);
        wc0 = mon_wr_cnt;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        n = 0;
        while (!(s_awready && s_wready) && n < TMO) begin tick(); n++; end
        check({name, ".grant"}, 64'(s_awready && s_wready), 64'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 1;
        while (!s_bvalid && n < TMO) begin tick(); n++; end
        check({name, ".b_latency"}, 64'(n), 64'd2);
        check({name, ".bresp"}, 64'(s_bresp), oob ? 64'(RESP_SLVERR) : 64'(RESP_OKAY));
        check({name, ".ram_writes"}, 64'(mon_wr_cnt - wc0), oob ? 64'd0 : 64'd1);
        if (!oob) begin
            check({name, ".ram_addr"}, 64'(mon_waddr), 64'(model_idx(a)));
            check({name, ".ram_din"}, 64'(mon_wdata), 64'(d));
            check({name, ".ram_wstrb"}, 64'(mon_wstrb), 64'(s));
        end
        model_write(a, d, s);
        s_bready = 1'b1;
        tick();
        check({name, ".bvalid_drop"}, 64'(s_bvalid), 64'd0);
        s_bready = 1'b0;
    endtask

    // One AXI read; optionally stalls RREADY while a competing write waits.
    task automatic axi_read(input string name, input logic [31:0] a, input int stall,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        int rc0;
        rc0 = mon_rd_cnt;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
        n = 0;
        while (!s_arready && n < TMO) begin tick(); n++; end
        check({name, ".grant"}, 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        n = 1;
        while (!s_rvalid && n < TMO) begin tick(); n++; end
        check({name, ".r_latency"}, 64'(n), 64'd2);
        check({name, ".rdata"}, 64'(s_rdata), 64'(exp_data));
        check({name, ".rresp"}, 64'(s_rresp), 64'(exp_resp));
        check({name, ".ram_reads"}, 64'(mon_rd_cnt - rc0), (exp_resp == RESP_OKAY) ? 64'd1 : 64'd0);
        for (int i = 0; i < stall; i++) begin
            s_awvalid = 1'b1; s_wvalid = 1'b1;
            tick();
            check({name, ".stall_rvalid"}, 64'(s_rvalid), 64'd1);
            check({name, ".stall_rdata"}, 64'(s_rdata), 64'(exp_data));
            check({name, ".stall_no_grant"}, 64'({s_awready, s_wready, s_arready}), 64'd0);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_rready = 1'b1;
        tick();
        check({name, ".rvalid_drop"}, 64'(s_rvalid), 64'd0);
        s_rready = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          stall;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [3:0]  order;
        logic [31:0] cdata;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_d;
        int          grants;
        int          reads_seen;
        int          cyc;
        int          en0;
        int          n;
        bit          bump;

        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'd0;
        rst = 1'b1; ram_clear = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) tick();
        rst = 1'b0; ram_clear = 1'b0;
        tick();

        // Reset state.
        check("reset.readies", 64'({s_awready, s_wready, s_arready}), 64'd0);
        check("reset.valids", 64'({s_bvalid, s_rvalid}), 64'd0);
        check("reset.resps", 64'({s_bresp, s_rresp}), 64'd0);
        check("reset.rdata", 64'(s_rdata), 64'd0);
        check("reset.ram_ctl", 64'({ram_en, ram_we, ram_wstrb}), 64'd0);

        // Simultaneous read and write requests from reset: grants go R, W, R, W.
        s_awaddr = 32'h40; s_araddr = 32'h40; s_wstrb = 4'hF; cdata = 32'hA1A1_0001;
        s_wdata = cdata;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        order = '0; grants = 0; reads_seen = 0; cyc = 0; bump = 1'b0;
        while (grants < 4 && cyc < 100) begin
            tick(); cyc++;
            if (bump) begin cdata = cdata + 32'd1; s_wdata = cdata; bump = 1'b0; end
            if (s_rvalid) begin
                exp_d = model_read(32'h40);
                check("arb.rdata", 64'(s_rdata), 64'(exp_d));
                reads_seen++;
            end
            if (s_arready) begin order = {order[2:0], 1'b1}; grants++; end
            if (s_awready && s_wready) begin
                order = {order[2:0], 1'b0}; grants++;
                model_write(32'h40, cdata, 4'hF);
                bump = 1'b1;
            end
        end
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        repeat (4) begin
            tick();
            if (s_rvalid) begin
                exp_d = model_read(32'h40);
                check("arb.rdata", 64'(s_rdata), 64'(exp_d));
                reads_seen++;
            end
        end
        s_bready = 1'b0; s_rready = 1'b0;
        check("arb.order_RWRW", 64'(order), 64'(4'b1010));
        check("arb.reads_done", 64'(reads_seen), 64'd2);

        // Directed transaction table.
        vecs[0]  = '{"t0_wr_full",   1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0, RESP_OKAY};
        vecs[1]  = '{"t1_rd_stall",  1'b0, 32'h10,   32'h0, 4'h0, 5, 32'hDEADBEEF, RESP_OKAY};
        vecs[2]  = '{"t2_wr_byte1",  1'b1, 32'h10,   32'h0000AB00, 4'b0010, 0, 32'h0, RESP_OKAY};
        vecs[3]  = '{"t3_rd_merge",  1'b0, 32'h10,   32'h0, 4'h0, 0, 32'hDEADABEF, RESP_OKAY};
        vecs[4]  = '{"t4_wr_hi",     1'b1, 32'h14,   32'h12345678, 4'b1100, 0, 32'h0, RESP_OKAY};
        vecs[5]  = '{"t5_rd_unalig", 1'b0, 32'h17,   32'h0, 4'h0, 0, 32'h12340000, RESP_OKAY};
        vecs[6]  = '{"t6_wr_strb0",  1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 0, 32'h0, RESP_OKAY};
        vecs[7]  = '{"t7_rd_strb0",  1'b0, 32'h20,   32'h0, 4'h0, 0, 32'h0, RESP_OKAY};
        vecs[8]  = '{"t8_rd_alias",  1'b0, 32'h1010, 32'h0, 4'h0, 0,
                     RANGE_CHECK ? 32'h0 : 32'hDEADABEF, RANGE_CHECK ? RESP_SLVERR : RESP_OKAY};
        vecs[9]  = '{"t9_wr_alias",  1'b1, 32'h1000, 32'h00000055, 4'hF, 0, 32'h0, RESP_OKAY};
        vecs[10] = '{"t10_rd_1000",  1'b0, 32'h1000, 32'h0, 4'h0, 0,
                     RANGE_CHECK ? 32'h0 : 32'h55, RANGE_CHECK ? RESP_SLVERR : RESP_OKAY};
        vecs[11] = '{"t11_rd_word0", 1'b0, 32'h0,    32'h0, 4'h0, 0,
                     RANGE_CHECK ? 32'h0 : 32'h55, RESP_OKAY};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) axi_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb);
            else axi_read(vecs[i].name, vecs[i].addr, vecs[i].stall, vecs[i].exp_rdata, vecs[i].exp_resp);
        end

        // AW arrives alone; no ready until W joins 3 cycles later.
        s_awaddr = 32'h30; s_wdata = 32'hCAFE0030; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("aw_alone.no_ready", 64'({s_awready, s_wready}), 64'd0);
        end
        axi_write("aw_then_w", 32'h30, 32'hCAFE0030, 4'hF);
        axi_read("aw_then_w.rd", 32'h30, 0, 32'hCAFE0030, RESP_OKAY);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write("rand_wr", a, d, s);
            end else begin
                exp_d = model_read(a);
                axi_read("rand_rd", a, $urandom_range(0, 2), exp_d,
                         model_oob(a) ? RESP_SLVERR : RESP_OKAY);
            end
        end

        // Reset while a read response is waiting: the response is abandoned.
        s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b0;
        n = 0;
        while (!s_arready && n < TMO) begin tick(); n++; end
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < TMO) begin tick(); n++; end
        check("rst_mid.rvalid_before", 64'(s_rvalid), 64'd1);
        en0 = mon_en_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_mid.rvalid_now", 64'(s_rvalid), 64'd0);
        check("rst_mid.state_idle", 64'(dut.state), 64'(IDLE));
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid.no_ram_enable", 64'(mon_en_cnt - en0), 64'd0);
        check("rst_mid.no_valid", 64'({s_rvalid, s_bvalid}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
